// File: rtl/i2s_tdm_pkg.sv
// Shared types and constants for the DSP/TDM transmit slot scheduler.
package i2s_tdm_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_SLOTS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [4:0]           num_bits;
    logic [3:0]           num_words;
    logic [MAX_SLOTS-1:0] slot_mask;
  } cfg_t;

endpackage

// File: rtl/i2s_tdm_shifter.sv
// Loadable left-shifting word register; serial output taken from a variable MSB position.
module i2s_tdm_shifter
  import i2s_tdm_pkg::*;
(
  input  logic              sck,
  input  logic              rstn,
  input  logic              load,
  input  logic              zero,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [4:0]        tap,
  output logic              sd
);

  logic [WORD_W-1:0] sreg;

  // zero wins over load so an empty or masked fetch can never leak stale data
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      sreg <= '0;
    end else if (zero) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= {sreg[WORD_W-2:0], 1'b0};
    end
  end

  assign sd = sreg[tap];

endmodule

// File: rtl/i2s_tdm_slot_sched.sv
// TDM frame/slot scheduler and serializer. Optional saturating error counters
// are built when I2S_TDM_ERR_CNT_EN is defined.
module i2s_tdm_slot_sched
  import i2s_tdm_pkg::*;
(
  input  logic                 sck_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [4:0]           cfg_num_bits_i,
  input  logic [3:0]           cfg_num_words_i,
  input  logic [MAX_SLOTS-1:0] cfg_slot_mask_i,
  input  logic                 ws_i,
  input  logic [WORD_W-1:0]    tx_data_i,
  input  logic                 tx_empty_i,
  output logic                 tx_pop_o,
  output logic                 ws_en_o,
  output logic                 sd_o,
  output logic                 active_o,
  output logic [3:0]           slot_idx_o,
  output logic [4:0]           bit_idx_o,
  output logic                 frame_start_o,
  output logic                 underrun_o,
  output logic                 frame_err_o,
  output logic [7:0]           underrun_cnt_o,
  output logic [7:0]           frame_err_cnt_o
);

  state_t     state_reg, state_next;
  cfg_t       cfg_reg;
  logic [4:0] bit_reg, bit_next;
  logic [3:0] slot_reg, slot_next;
  logic [3:0] fetch_slot;
  logic       latch_cfg, fetch, advance, resync, frame_err;
  logic       last_bit, last_cycle, slot_en, zero;

  assign last_bit   = (bit_reg == cfg_reg.num_bits);
  assign last_cycle = last_bit && (slot_reg == cfg_reg.num_words);

  always_comb begin
    state_next = state_reg;
    latch_cfg  = 1'b0;
    fetch      = 1'b0;
    fetch_slot = '0;
    advance    = 1'b0;
    resync     = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_en_i) begin
          state_next = ST_ARM;
          latch_cfg  = 1'b1;
        end
      end
      ST_ARM: begin
        if (!cfg_en_i) begin
          state_next = ST_IDLE;
        end else if (ws_i) begin
          state_next = ST_RUN;
          fetch      = 1'b1;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (!cfg_en_i) state_next = ST_DRAIN;
        if (ws_i && !last_cycle) begin
          frame_err = 1'b1;
          resync    = 1'b1;
          fetch     = 1'b1;
        end else if (last_bit) begin
          fetch      = 1'b1;
          fetch_slot = last_cycle ? 4'd0 : slot_reg + 4'd1;
        end
      end
      ST_DRAIN: begin
        // the frame in flight completes; nothing is fetched for the next one
        advance = 1'b1;
        if (ws_i && !last_cycle) frame_err = 1'b1;
        if (last_cycle) begin
          state_next = ST_IDLE;
        end else if (last_bit) begin
          fetch      = 1'b1;
          fetch_slot = slot_reg + 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_next  = '0;
    slot_next = '0;
    if (advance && !resync) begin
      if (last_bit) begin
        slot_next = (slot_reg == cfg_reg.num_words) ? 4'd0 : slot_reg + 4'd1;
      end else begin
        bit_next  = bit_reg + 5'd1;
        slot_next = slot_reg;
      end
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= ST_IDLE;
      cfg_reg   <= '0;
      bit_reg   <= '0;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      slot_reg  <= slot_next;
      if (latch_cfg) cfg_reg <= {cfg_num_bits_i, cfg_num_words_i, cfg_slot_mask_i};
    end
  end

  assign slot_en     = cfg_reg.slot_mask[fetch_slot];
  assign tx_pop_o    = fetch && slot_en && !tx_empty_i;
  assign underrun_o  = fetch && slot_en && tx_empty_i;
  assign frame_err_o = frame_err;
  assign zero        = (fetch && !tx_pop_o) || (state_reg == ST_DRAIN && last_cycle);

  assign active_o      = (state_reg != ST_IDLE);
  assign ws_en_o       = (state_reg != ST_IDLE);
  assign slot_idx_o    = slot_reg;
  assign bit_idx_o     = bit_reg;
  assign frame_start_o = (state_reg == ST_RUN || state_reg == ST_DRAIN) &&
                         (bit_reg == 5'd0) && (slot_reg == 4'd0);

  i2s_tdm_shifter u_shifter (
    .sck   (sck_i),
    .rstn  (rstn_i),
    .load  (tx_pop_o),
    .zero  (zero),
    .shift (advance),
    .data  (tx_data_i),
    .tap   (cfg_reg.num_bits),
    .sd    (sd_o)
  );

`ifdef I2S_TDM_ERR_CNT_EN
  logic [7:0] und_cnt_reg, ferr_cnt_reg;

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      und_cnt_reg  <= '0;
      ferr_cnt_reg <= '0;
    end else if (latch_cfg) begin
      und_cnt_reg  <= '0;
      ferr_cnt_reg <= '0;
    end else begin
      if (underrun_o && und_cnt_reg != 8'hFF) und_cnt_reg <= und_cnt_reg + 8'd1;
      if (frame_err && ferr_cnt_reg != 8'hFF) ferr_cnt_reg <= ferr_cnt_reg + 8'd1;
    end
  end

  assign underrun_cnt_o  = und_cnt_reg;
  assign frame_err_cnt_o = ferr_cnt_reg;
`else
  assign underrun_cnt_o  = 8'd0;
  assign frame_err_cnt_o = 8'd0;
`endif

endmodule

// File: doc/i2s_tdm_slot_sched.md
# i2s_tdm_slot_sched

Frame/slot scheduler and serializer for the DSP/TDM transmit path, clocked by the serial clock. Enables the DSP word-select generator, locks onto its frame pulse, and tracks bit and slot position within each frame. Fetches one word per enabled slot from a first-word-fall-through TX FIFO and shifts it out MSB first. Start and stop are frame-aligned; underruns and unexpected frame pulses are flagged.

## Interface
- No parameters; word width fixed at 32, max 16 slots.
- sck_i  in  1  serial clock; all logic on posedge
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  run request (level)
- cfg_num_bits_i  in  5  bits per slot minus 1 (0..31)
- cfg_num_words_i  in  4  slots per frame minus 1 (0..15)
- cfg_slot_mask_i  in  16  bit n = 1: slot n carries data
- ws_i  in  1  frame pulse from WS generator, one sck cycle wide
- tx_data_i  in  32  FIFO head word, right-aligned (valid bits [num_bits:0])
- tx_empty_i  in  1  FIFO empty
- tx_pop_o  out  1  consume FIFO head at this edge
- ws_en_o  out  1  enable to WS generator
- sd_o  out  1  serial data
- active_o  out  1  high in ARM/RUN/DRAIN
- slot_idx_o  out  4  current slot
- bit_idx_o  out  5  current bit within slot, 0 = MSB
- frame_start_o  out  1  high during slot 0 bit 0
- underrun_o  out  1  one-cycle pulse
- frame_err_o  out  1  one-cycle pulse
- underrun_cnt_o  out  8  saturating count (see Configuration)
- frame_err_cnt_o  out  8  saturating count (see Configuration)

## Operation
- States: IDLE, ARM, RUN, DRAIN.
- IDLE: cfg_en_i=1 -> latch num_bits, num_words, slot_mask into shadow registers; go to ARM. Shadows change only here.
- ARM: ws_en_o=1. ws_i=1 -> RUN, counters to slot 0 bit 0 on the next edge. cfg_en_i=0 -> IDLE.
- RUN: bit counter 0..num_bits. At wrap, slot counter increments 0..num_words and then wraps to 0.
  - A ws_i pulse is expected only in the last-bit-of-last-slot cycle.
  - ws_i elsewhere: frame_err_o pulses and the counters resync to slot 0 bit 0.
  - cfg_en_i=0 -> DRAIN.
- DRAIN: the current frame completes. After the last bit of the last slot -> IDLE, with ws_en_o=0 on that edge.
  - No pops are issued for a following frame.
  - cfg_en_i returning high is ignored until IDLE is reached.
- Fetch point: the cycle before bit 0 of an enabled slot. This is the ws_i cycle for slot 0, otherwise the last bit of the previous slot.
  - At the fetch point, tx_pop_o = !tx_empty_i (combinational) and tx_data_i loads the shift register.
  - Empty at the fetch point: load zeros, underrun_o pulses, no pop.
- Masked slot: no pop, shift register loaded with zero.
- sd_o = shift_reg[num_bits]; the register shifts left one bit per cycle.

## Timing
- Reset values:
  - State IDLE; all outputs 0; shift register, shadows and counters 0.
  - Reset mid-frame aborts immediately and issues no pop.
- ws_i high at edge N -> slot 0 bit 0 (MSB) appears on sd_o after edge N+1.
- Frame length = (num_bits+1)*(num_words+1) cycles; the next ws_i must arrive in the final cycle.
- slot_idx_o, bit_idx_o and frame_start_o are registered and valid in RUN/DRAIN; they are 0 in IDLE/ARM.
- tx_pop_o is high for at most one cycle per enabled slot.
- num_bits=0 gives one-bit slots: the fetch point occurs every cycle.
- Simultaneous empty and unexpected ws_i: both flags pulse, the counters resync, and zeros are loaded.
- Counter width: bit counter 5 bits, slot counter 4 bits; there is no overflow past the configured limits.

## Configuration
- I2S_TDM_ERR_CNT_EN defined:
  - underrun_cnt_o and frame_err_cnt_o count the respective pulses, saturating at 255.
  - Both clear on reset and on the IDLE->ARM transition.
- Not defined: both ports are tied to 0 and no counter flops exist. The pulse outputs are unaffected.

## Structure
- Shared package i2s_tdm_pkg holds:
  - the state enum;
  - constants MAX_SLOTS=16 and WORD_W=32;
  - a struct for the shadowed configuration.
- One sub-module, i2s_tdm_shifter: a 32-bit loadable shift register with variable MSB tap, plus load/zero controls.
- The FSM and counters stay in the top module.

## Test plan
- num_bits=15, num_words=1, mask=0x3, FIFO holds 0xA5A5 and 0x0F0F; enable, then ws_i pulse:
  - sd_o = 0xA5A5 MSB-first, then 0x0F0F;
  - two pops, at slot 0 and slot 1 fetch points.
- num_bits=7, num_words=3, mask=0x5, FIFO with 4 words:
  - only slots 0 and 2 pop;
  - slots 1 and 3 drive 8 zero bits each.
- Empty FIFO at the slot 1 fetch point: underrun_o pulses once, slot 1 is all zeros, tx_pop_o stays low. With I2S_TDM_ERR_CNT_EN, underrun_cnt_o = 1.
- ws_i injected at slot 0 bit 3:
  - frame_err_o pulses;
  - slot_idx_o = 0 and bit_idx_o = 0 on the next cycle;
  - the frame restarts cleanly.
- cfg_en_i dropped mid-slot 1 of 4:
  - frame completes to slot 3 last bit;
  - ws_en_o and active_o fall on the same edge;
  - no further pops.
- rstn_i asserted mid-frame: all outputs 0 immediately and state IDLE. Re-enable and ws_i restart from slot 0.
